// File: rtl/aes_core_arbiter_if.sv
// aes_core_arbiter_if: groups the two requester channels, the AES core
// connection, and the status outputs of aes_core_arbiter into one bundle.
// The slave modport is the arbiter side. The master modport is the
// requester/core side.
interface aes_core_arbiter_if;
  // Requester 0 (handshake engine)
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_key;
  logic [127:0] req0_data;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [127:0] rsp0_data;

  // Requester 1 (record layer)
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_key;
  logic [127:0] req1_data;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [127:0] rsp1_data;

  // Shared combinational AES core
  logic [127:0] aes_key;
  logic [127:0] aes_data;
  logic [127:0] aes_cdata;

  // Status
  logic         busy;
  logic [15:0]  stat_cnt0;
  logic [15:0]  stat_cnt1;

  modport slave (
    input  req0_valid, req0_key, req0_data, rsp0_ready,
    input  req1_valid, req1_key, req1_data, rsp1_ready,
    input  aes_cdata,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output aes_key, aes_data,
    output busy, stat_cnt0, stat_cnt1
  );

  modport master (
    output req0_valid, req0_key, req0_data, rsp0_ready,
    output req1_valid, req1_key, req1_data, rsp1_ready,
    output aes_cdata,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  aes_key, aes_data,
    input  busy, stat_cnt0, stat_cnt1
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sequencer that shares one combinational
// AES-128 core between two requesters.
//
// Operation:
// - The granted key and plaintext are registered onto the core inputs.
// - The inputs are held for SETTLE_CYCLES (legal range 1..15), then the
//   ciphertext is captured.
// - The ciphertext is returned on the owner's response channel.
// - After the response is consumed, the core inputs and the response
//   register are zeroized.
//
// Optional per-requester completion counters are built when the macro
// AES_CORE_ARB_STATS_EN is defined. Otherwise stat_cnt0/stat_cnt1 read 0.
module aes_core_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  aes_core_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 32'd1);

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] aes_key_q, aes_key_d;
  logic [127:0] aes_data_q, aes_data_d;
  logic [127:0] resp_q, resp_d;

  logic         grant0;
  logic         grant1;
  logic         rsp_fire;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Next-state logic: load core inputs, count out the settle time, capture, then zeroize.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    aes_key_d    = aes_key_q;
    aes_data_d   = aes_data_q;
    resp_d       = resp_q;
    rsp_fire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          aes_key_d    = grant1 ? bus.req1_key  : bus.req0_key;
          aes_data_d   = grant1 ? bus.req1_data : bus.req0_data;
          owner_d      = grant1;
          last_grant_d = grant1;
          cnt_d        = CNT_LOAD;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          resp_d  = bus.aes_cdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_fire = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          aes_key_d  = 128'd0;
          aes_data_d = 128'd0;
          resp_d     = 128'd0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        aes_key_d  = 128'd0;
        aes_data_d = 128'd0;
        resp_d     = 128'd0;
        cnt_d      = 4'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      aes_key_q    <= 128'd0;
      aes_data_q   <= 128'd0;
      resp_q       <= 128'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      aes_key_q    <= aes_key_d;
      aes_data_q   <= aes_data_d;
      resp_q       <= resp_d;
    end
  end

  // Outputs are decoded from registered state only, except the IDLE grants.
  // Ciphertext is gated so a non-owner always sees zero data.
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) && owner_q;
  assign bus.rsp0_data  = bus.rsp0_valid ? resp_q : 128'd0;
  assign bus.rsp1_data  = bus.rsp1_valid ? resp_q : 128'd0;
  assign bus.aes_key    = aes_key_q;
  assign bus.aes_data   = aes_data_q;
  assign bus.busy       = (state_q != ST_IDLE);

`ifdef AES_CORE_ARB_STATS_EN
  logic [15:0] stat_cnt0_q, stat_cnt0_d;
  logic [15:0] stat_cnt1_q, stat_cnt1_d;

  // Count completed responses per owner, saturating at all-ones.
  always_comb begin
    stat_cnt0_d = stat_cnt0_q;
    stat_cnt1_d = stat_cnt1_q;
    if (rsp_fire && !owner_q && (stat_cnt0_q != 16'hFFFF)) begin
      stat_cnt0_d = stat_cnt0_q + 16'd1;
    end else if (rsp_fire && owner_q && (stat_cnt1_q != 16'hFFFF)) begin
      stat_cnt1_d = stat_cnt1_q + 16'd1;
    end else begin
      stat_cnt0_d = stat_cnt0_q;
      stat_cnt1_d = stat_cnt1_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0_q <= 16'd0;
      stat_cnt1_q <= 16'd0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign bus.stat_cnt0 = stat_cnt0_q;
  assign bus.stat_cnt1 = stat_cnt1_q;
`else
  assign bus.stat_cnt0 = 16'h0000;
  assign bus.stat_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: scoreboard bench for aes_core_arbiter.
// The AES core is stood in for by a lookup of the two FIPS-197 vectors;
// any other key/data pair maps through a fixed mixing function.
// Expected ciphertexts are pushed at each handshake and popped when the
// response is consumed.
`timescale 1ns/1ps
module tb_aes_core_arbiter;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] P2 = 128'hcafef00d55aa55aa0f0f0f0f12345678;

  typedef struct {
    int           id;
    logic [127:0] ct;
    int           hs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   hs_cnt0 = 0;
  int   hs_cnt1 = 0;
  int   hs_cyc0 = 0;
  int   hs_cyc1 = 0;
  logic prev_v0 = 1'b0;
  logic prev_v1 = 1'b0;

  aes_core_arbiter_if bus ();
  aes_core_arbiter_if bs1 ();
  aes_core_arbiter_if bs5 ();

  aes_core_arbiter #(.SETTLE_CYCLES(2)) dut    (.clk(clk), .rst(rst), .bus(bus));
  aes_core_arbiter #(.SETTLE_CYCLES(1)) dut_s1 (.clk(clk), .rst(rst), .bus(bs1));
  aes_core_arbiter #(.SETTLE_CYCLES(5)) dut_s5 (.clk(clk), .rst(rst), .bus(bs5));

  // Reference AES stand-in: known vectors, otherwise a fixed reversible mix.
  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] d);
    if (k == K0 && d == P0) return C0;
    else if (k == K1 && d == P1) return C1;
    else return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  assign bus.aes_cdata = aes_model(bus.aes_key, bus.aes_data);
  assign bs1.aes_cdata = aes_model(bs1.aes_key, bs1.aes_data);
  assign bs5.aes_cdata = aes_model(bs5.aes_key, bs5.aes_data);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshake tracker: sampled mid-cycle, committed at the edge, pushes expectations.
  initial begin : hs_track
    bit   p0;
    bit   p1;
    exp_t e;
    forever begin
      @(negedge clk);
      p0 = bus.req0_valid && bus.req0_ready && !rst;
      p1 = bus.req1_valid && bus.req1_ready && !rst;
      e.id = 0;
      e.ct = aes_model(bus.req0_key, bus.req0_data);
      @(posedge clk);
      if (p0) begin
        e.hs = cyc;
        sb.push_back(e);
        hs_cnt0++;
        hs_cyc0 = cyc;
      end
      if (p1) begin
        e.id = 1;
        e.ct = aes_model(bus.req1_key, bus.req1_data);
        e.hs = cyc;
        sb.push_back(e);
        hs_cnt1++;
        hs_cyc1 = cyc;
      end
    end
  end

  task automatic mon_port(input int n, input logic v, input logic r,
                          input logic [127:0] d, input logic pv);
    exp_t e;
    if (v) begin
      if (sb.size() == 0) begin
        check($sformatf("rsp%0d_unexpected", n), 128'(v), 128'd0);
      end else begin
        e = sb[0];
        check($sformatf("rsp%0d_owner", n), 128'(n), 128'(e.id));
        if (!pv) check($sformatf("rsp%0d_latency", n), 128'(cyc - e.hs), 128'd3);
        check($sformatf("rsp%0d_data", n), d, e.ct);
        if (r) void'(sb.pop_front());
      end
    end else begin
      check($sformatf("rsp%0d_data_zero", n), d, 128'd0);
    end
  endtask

  // Response monitor: compares each response against the scoreboard head.
  initial begin : rsp_mon
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_port(0, bus.rsp0_valid, bus.rsp0_ready, bus.rsp0_data, prev_v0);
        mon_port(1, bus.rsp1_valid, bus.rsp1_ready, bus.rsp1_data, prev_v1);
      end
      prev_v0 = bus.rsp0_valid;
      prev_v1 = bus.rsp1_valid;
    end
  end

  // Raise the selected requests, drop each after its handshake, scramble its inputs.
  task automatic run_reqs(input bit en0, input logic [127:0] k0, input logic [127:0] d0,
                          input bit en1, input logic [127:0] k1, input logic [127:0] d1);
    int c0 = hs_cnt0;
    int c1 = hs_cnt1;
    bit done0 = !en0;
    bit done1 = !en1;
    if (en0) begin
      bus.req0_key = k0; bus.req0_data = d0; bus.req0_valid = 1'b1;
    end
    if (en1) begin
      bus.req1_key = k1; bus.req1_data = d1; bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 100 && !(done0 && done1); i++) begin
      @(posedge clk); #1;
      if (!done0 && hs_cnt0 != c0) begin
        done0 = 1'b1; bus.req0_valid = 1'b0; bus.req0_key = '1; bus.req0_data = '1;
      end
      if (!done1 && hs_cnt1 != c1) begin
        done1 = 1'b1; bus.req1_valid = 1'b0; bus.req1_key = '1; bus.req1_data = '1;
      end
    end
    check("hs_timeout", 128'(done0 && done1), 128'd1);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while (i < 100 && (sb.size() != 0 || bus.busy)) begin
      @(posedge clk); #1;
      i++;
    end
    check(tag, 128'(sb.size() == 0 && !bus.busy), 128'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int     lat1;
    int     lat5;
    logic [127:0] ct1;
    logic [127:0] ct5;
    logic   seen;
    int     c1;
    bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_data = '0; bus.rsp0_ready = 1'b1;
    bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_data = '0; bus.rsp1_ready = 1'b1;
    bs1.req0_valid = 1'b0; bs1.req0_key = '0; bs1.req0_data = '0; bs1.rsp0_ready = 1'b1;
    bs1.req1_valid = 1'b0; bs1.req1_key = '0; bs1.req1_data = '0; bs1.rsp1_ready = 1'b1;
    bs5.req0_valid = 1'b0; bs5.req0_key = '0; bs5.req0_data = '0; bs5.rsp0_ready = 1'b1;
    bs5.req1_valid = 1'b0; bs5.req1_key = '0; bs5.req1_data = '0; bs5.rsp1_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     128'(bus.busy),       128'd0);
    check("rst_ready0",   128'(bus.req0_ready), 128'd0);
    check("rst_ready1",   128'(bus.req1_ready), 128'd0);
    check("rst_rsp0v",    128'(bus.rsp0_valid), 128'd0);
    check("rst_rsp1v",    128'(bus.rsp1_valid), 128'd0);
    check("rst_aes_key",  bus.aes_key,          128'd0);
    check("rst_aes_data", bus.aes_data,         128'd0);
    check("rst_stat0",    128'(bus.stat_cnt0),  128'd0);
    check("rst_stat1",    128'(bus.stat_cnt1),  128'd0);
    rst = 1'b0;

    // Simultaneous requests straight after reset: requester 0 first, 1 four cycles later.
    run_reqs(1'b1, K0, P0, 1'b1, K1, P1);
    check("tie_gap", 128'(hs_cyc1 - hs_cyc0), 128'd4);
    drain("drain_tie");

    // Single request on requester 0.
    run_reqs(1'b1, K0, P0, 1'b0, '0, '0);
    drain("drain_single");

    // Backpressure on requester 1 while requester 0 waits.
    bus.rsp1_ready = 1'b0;
    run_reqs(1'b0, '0, '0, 1'b1, K1, P1);
    bus.req0_key = K0; bus.req0_data = P0; bus.req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp1_valid;
    end
    check("bp_rsp_seen", 128'(seen), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp1_valid", 128'(bus.rsp1_valid), 128'd1);
      check("bp_rsp1_data",  bus.rsp1_data,         C1);
      check("bp_req0_ready", 128'(bus.req0_ready),  128'd0);
      check("bp_busy",       128'(bus.busy),        128'd1);
    end
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    check("zero_aes_key",  bus.aes_key,  128'd0);
    check("zero_aes_data", bus.aes_data, 128'd0);
    run_reqs(1'b1, K0, P0, 1'b0, '0, '0);
    drain("drain_bp");

    // Reset during SETTLE: last grant was 0, so the tie goes to requester 1.
    c1 = hs_cnt1;
    bus.req0_key = K0; bus.req0_data = P0; bus.req0_valid = 1'b1;
    bus.req1_key = K1; bus.req1_data = P1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 20 && hs_cnt1 == c1; i++) begin
      @(posedge clk); #1;
    end
    check("mr_hs1", 128'(hs_cnt1 - c1), 128'd1);
    check("mr_in_settle", 128'(bus.busy), 128'd1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_busy",      128'(bus.busy),       128'd0);
    check("mr_ready0",    128'(bus.req0_ready), 128'd0);
    check("mr_ready1",    128'(bus.req1_ready), 128'd0);
    check("mr_rsp0v",     128'(bus.rsp0_valid), 128'd0);
    check("mr_rsp1v",     128'(bus.rsp1_valid), 128'd0);
    check("mr_aes_key",   bus.aes_key,          128'd0);
    check("mr_aes_data",  bus.aes_data,         128'd0);
    sb.delete();
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run_reqs(1'b1, K0, P0, 1'b1, K1, P1);
    check("mr_tie_gap", 128'(hs_cyc1 - hs_cyc0), 128'd4);
    drain("drain_mr");

    // Stats: fresh reset, three transactions on 0 and two on 1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_reqs(1'b1, K2 ^ 128'(i), P2, 1'b0, '0, '0);
      drain("drain_stat0");
    end
    for (int i = 0; i < 2; i++) begin
      run_reqs(1'b0, '0, '0, 1'b1, K2, P2 ^ 128'(i));
      drain("drain_stat1");
    end
`ifdef AES_CORE_ARB_STATS_EN
    check("stat_cnt0", 128'(bus.stat_cnt0), 128'd3);
    check("stat_cnt1", 128'(bus.stat_cnt1), 128'd2);
`else
    check("stat_cnt0", 128'(bus.stat_cnt0), 128'd0);
    check("stat_cnt1", 128'(bus.stat_cnt1), 128'd0);
`endif

    // Parameter sweep: SETTLE_CYCLES 1 and 5 give latency 2 and 6.
    bs1.req0_key = K0; bs1.req0_data = P0; bs1.req0_valid = 1'b1;
    bs5.req0_key = K0; bs5.req0_data = P0; bs5.req0_valid = 1'b1;
    @(negedge clk);
    check("sw1_ready", 128'(bs1.req0_ready), 128'd1);
    check("sw5_ready", 128'(bs5.req0_ready), 128'd1);
    @(posedge clk); #1;
    bs1.req0_valid = 1'b0; bs1.req0_key = '1;
    bs5.req0_valid = 1'b0; bs5.req0_key = '1;
    lat1 = 0; lat5 = 0; ct1 = '0; ct5 = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bs1.rsp0_valid && lat1 == 0) begin lat1 = n; ct1 = bs1.rsp0_data; end
      if (bs5.rsp0_valid && lat5 == 0) begin lat5 = n; ct5 = bs5.rsp0_data; end
    end
    check("sw1_latency", 128'(lat1), 128'd2);
    check("sw5_latency", 128'(lat5), 128'd6);
    check("sw1_data", ct1, C0);
    check("sw5_data", ct5, C0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Sequencer and round-robin arbiter that shares one combinational `AES_top` AES-128 encryption core between two requesters: requester 0 is the handshake engine and requester 1 is the record layer. It registers the granted key and plaintext onto the core inputs and waits a fixed settle time for the deep combinational path. It then captures the ciphertext and returns it on a per-requester valid/ready response channel. After each response is consumed, it zeroizes the core inputs.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the core inputs are held before `c_data` is captured; legal range 1..15.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req0_valid` input 1: requester 0 has a block to encrypt.
- `req0_ready` output 1: requester 0 request accepted this cycle.
- `req0_key` input 128: requester 0 AES-128 key.
- `req0_data` input 128: requester 0 plaintext block.
- `rsp0_valid` output 1: requester 0 ciphertext available.
- `rsp0_ready` input 1: requester 0 consumes the response.
- `rsp0_data` output 128: requester 0 ciphertext.
- `req1_*` / `rsp1_*`: same set as requester 0, for requester 1.
- `aes_key` output 128: drives `AES_top.key`.
- `aes_data` output 128: drives `AES_top.data`.
- `aes_cdata` input 128: from `AES_top.c_data`.
- `busy` output 1: high in any state other than IDLE.
- `stat_cnt0` output 16: completed transactions for requester 0; present only with the stats macro, otherwise 0.
- `stat_cnt1` output 16: completed transactions for requester 1; present only with the stats macro, otherwise 0.

## Operation
- FSM has three states: IDLE, SETTLE, RESP.
- **IDLE**
  - Grant is combinational from `req0_valid`, `req1_valid` and the `last_grant` register.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester that is not `last_grant` is granted.
  - `reqN_ready` equals `grantN`. It is never high outside IDLE, and at most one `ready` is high at a time.
  - On a handshake (`valid && ready`):
    - `aes_key` and `aes_data` load from the granted requester.
    - `owner` and `last_grant` are set to N.
    - The settle counter is set to `SETTLE_CYCLES-1`.
    - The FSM moves to SETTLE.
- **SETTLE**
  - Core inputs are held stable.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, `aes_cdata` is captured into the response register and the FSM moves to RESP.
- **RESP**
  - `rsp<owner>_valid` is high and `rsp<owner>_data` equals the captured ciphertext.
  - The other requester's `rsp_valid` stays 0.
  - On `rsp<owner>_ready`:
    - `rsp_valid` drops.
    - `aes_key`, `aes_data` and the response register are cleared to 0.
    - The FSM moves to IDLE.
- **Data exposure:** `rspN_data` reads 0 whenever `rspN_valid` is low, so ciphertext is never exposed to the wrong requester.
- **Request inputs outside IDLE:** `reqN_key` and `reqN_data` are ignored; only the values at the handshake cycle are used.
- **Reset values**
  - State = IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - All `ready`/`valid` outputs = 0, `busy` = 0.
  - `aes_key` = `aes_data` = 0, response register = 0, stats = 0.
- **Reset during operation:** `rst` in SETTLE or RESP aborts the transaction with no response. The next cycle shows all reset values.
- **No preemption:** a request arriving while busy waits; a requester may hold `valid` indefinitely.

## Timing
- Handshake at edge T0 (IDLE). `aes_key`/`aes_data` are valid from T0+1.
- Capture occurs at edge T0+`SETTLE_CYCLES`. `rspN_valid` is high from T0+`SETTLE_CYCLES`+1.
- With the default (2): accept at cycle 0, response visible at cycle 3.
- If `rsp_ready` is already high when `rsp_valid` rises, the FSM is back in IDLE one cycle later. The next `ready` can be asserted in that IDLE cycle.
- Minimum issue interval is `SETTLE_CYCLES`+2 cycles.
- Back-to-back ties alternate grants 0,1,0,1.
- `SETTLE_CYCLES` must cover the `AES_top` combinational delay at the target clock; the block does not check this.

## Configuration
- Macro: `AES_CORE_ARB_STATS_EN`.
- **Defined:**
  - `stat_cnt0` and `stat_cnt1` increment on each RESP→IDLE exit for the owner.
  - The counters saturate at 16'hFFFF and clear on `rst`.
- **Undefined:** the counters are not built and `stat_cnt0`/`stat_cnt1` are tied to 16'h0000.

## Test plan
- **Single request:** requester 0 sends key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, with `rsp0_ready`=1.
  - Required: `rsp0_valid` at accept+3 with `rsp0_data` 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `rsp1_valid` stays 0 throughout.
- **Simultaneous requests:** requester 0 uses the vector above; requester 1 sends key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734.
  - Required: requester 0 is served first; requester 1 then gets 3925841d02dc09fbdc118597196a0b32.
  - Requester 1's accept occurs in the cycle after requester 0's RESP exits, at cycle 4 relative to the first accept.
- **Response backpressure:** hold `rsp1_ready`=0 for 10 cycles.
  - Required: `rsp1_valid` and `rsp1_data` stay stable, `req0_ready` stays 0, and `busy` stays 1.
  - On release, `aes_key` and `aes_data` read 0 in the next cycle.
- **Mid-operation reset:** assert `rst` in SETTLE.
  - Required: the next cycle shows IDLE, all outputs 0, and no `rsp_valid` ever appears.
  - After reset, a tie grants requester 0.
- **Stats (with `AES_CORE_ARB_STATS_EN`):** run 3 transactions on requester 0 and 2 on requester 1.
  - Required: `stat_cnt0`=3 and `stat_cnt1`=2.
  - Without the macro, both read 0.
- **Parameter sweep:** run with `SETTLE_CYCLES`=1 and 5.
  - Required: response latency is 2 and 6 cycles respectively, and the ciphertext is unchanged.
